// File: rtl/display_scanner_pkg.sv
// Shared types and constants for the multiplexed seven-segment display scanner.
package display_scanner_pkg;

    localparam logic [3:0] BLANK_CODE = 4'hF;
    localparam int         MAX_DIGITS = 8;

    typedef logic [3:0] digit_code_t;

endpackage

// File: rtl/display_scanner_if.sv
// Digit/dot inputs and decoder/anode outputs of the display scanner.
interface display_scanner_if
    import display_scanner_pkg::*;
#(
    parameter int NUM_DIGITS = 8
);
    logic [4*NUM_DIGITS-1:0] digits_in;
    logic [NUM_DIGITS-1:0]   dots_in;
    logic                    lz_blank_en;
    digit_code_t             digit_code;
    logic                    digit_dot;
    logic [NUM_DIGITS-1:0]   anode_n;
    logic                    frame_tick;

    modport master (
        output digits_in, dots_in, lz_blank_en,
        input  digit_code, digit_dot, anode_n, frame_tick
    );

    modport slave (
        input  digits_in, dots_in, lz_blank_en,
        output digit_code, digit_dot, anode_n, frame_tick
    );
endinterface

// File: rtl/display_scanner_lz_blanker.sv
// Leading-zero blanking: zeros without a lit dot above the first significant
// digit become BLANK_CODE; digit 0 always shows.
module display_scanner_lz_blanker
    import display_scanner_pkg::*;
#(
    parameter int NUM_DIGITS = 8
) (
    input  logic [4*NUM_DIGITS-1:0]       digits_i,
    input  logic [NUM_DIGITS-1:0]         dots_i,
    input  logic                          lz_en_i,
    output digit_code_t [NUM_DIGITS-1:0]  codes_o
);

    always_comb begin
        logic blanking;
        blanking = lz_en_i;
        codes_o  = '0;
        for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
            if (blanking && (k != 0) && (digits_i[4*k +: 4] == 4'h0) && !dots_i[k]) begin
                codes_o[k] = BLANK_CODE;
            end else begin
                codes_o[k] = digits_i[4*k +: 4];
                blanking   = 1'b0;
            end
        end
    end

endmodule

// File: rtl/display_scanner.sv
// Time-multiplexes NUM_DIGITS BCD digits onto one decoder and a common-anode
// digit array, with a per-frame input snapshot and an anti-ghosting blank window.
module display_scanner
    import display_scanner_pkg::*;
#(
    parameter int NUM_DIGITS   = 8,
    parameter int REFRESH_DIV  = 50000,
    parameter int BLANK_CYCLES = 500
) (
    input  logic              clk,
    input  logic              reset,
    display_scanner_if.slave  bus
);

    localparam int PRE_W = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
    localparam int IDX_W = $clog2(NUM_DIGITS);
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(REFRESH_DIV - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);

    logic [PRE_W-1:0]             pre_q, pre_d;
    logic [IDX_W-1:0]             idx_q, idx_d;
    digit_code_t [NUM_DIGITS-1:0] sh_code_q, sh_code_d, blanked;
    logic [NUM_DIGITS-1:0]        sh_dot_q, sh_dot_d;
    logic                         load_pending_q;
    digit_code_t                  code_q, code_d;
    logic                         dot_q, dot_d;
    logic [NUM_DIGITS-1:0]        anode_q, anode_d;
    logic                         tick_q, tick_d;
    logic                         boundary, snap;

    display_scanner_lz_blanker #(.NUM_DIGITS(NUM_DIGITS)) u_lz_blanker (
        .digits_i (bus.digits_in),
        .dots_i   (bus.dots_in),
        .lz_en_i  (bus.lz_blank_en),
        .codes_o  (blanked)
    );

    always_comb begin
        boundary = (pre_q == PRE_LAST);
        snap     = load_pending_q || (boundary && (idx_q == IDX_LAST));
        pre_d    = pre_q;
        idx_d    = idx_q;
        // The post-reset load only fills the shadow registers; the scan holds still.
        if (!load_pending_q) begin
            if (boundary) begin
                pre_d = '0;
                idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + IDX_W'(1);
            end else begin
                pre_d = pre_q + PRE_W'(1);
            end
        end
        sh_code_d = snap ? blanked     : sh_code_q;
        sh_dot_d  = snap ? bus.dots_in : sh_dot_q;
        // Outputs come from next-state values so code and anode switch together.
        code_d  = sh_code_d[idx_d];
        dot_d   = ~sh_dot_d[idx_d];
        anode_d = (int'(pre_d) < BLANK_CYCLES) ? '1 : ~(NUM_DIGITS'(1) << idx_d);
        tick_d  = snap;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pre_q          <= '0;
            idx_q          <= '0;
            sh_code_q      <= '1;
            sh_dot_q       <= '0;
            load_pending_q <= 1'b1;
            code_q         <= BLANK_CODE;
            dot_q          <= 1'b1;
            anode_q        <= '1;
            tick_q         <= 1'b0;
        end else begin
            pre_q          <= pre_d;
            idx_q          <= idx_d;
            sh_code_q      <= sh_code_d;
            sh_dot_q       <= sh_dot_d;
            load_pending_q <= 1'b0;
            code_q         <= code_d;
            dot_q          <= dot_d;
            anode_q        <= anode_d;
            tick_q         <= tick_d;
        end
    end

    assign bus.digit_code = code_q;
    assign bus.digit_dot  = dot_q;
    assign bus.anode_n    = anode_q;
    assign bus.frame_tick = tick_q;

endmodule

// File: tb/tb_display_scanner.sv
// Scoreboard bench for display_scanner: 4 digits, 4-cycle slots, blank window
// of 1 cycle on the main instance and 0 cycles on a second instance.
module tb_display_scanner;

    logic clk;
    logic reset;

    display_scanner_if #(.NUM_DIGITS(4)) bus  ();
    display_scanner_if #(.NUM_DIGITS(4)) bus0 ();

    display_scanner #(.NUM_DIGITS(4), .REFRESH_DIV(4), .BLANK_CYCLES(1)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    display_scanner #(.NUM_DIGITS(4), .REFRESH_DIV(4), .BLANK_CYCLES(0)) dut0 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus0)
    );

    typedef struct {
        logic [3:0] code;
        logic       dot;
        logic [3:0] an;
        logic       tick;
    } exp_t;

    exp_t q[$];
    int   vectors     = 0;
    int   miscompares = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    // Expected per-cycle outputs for one full frame starting at a snapshot edge.
    task automatic push_frame(input logic [15:0] d, input logic [3:0] dt,
                              input bit lz, input int blank);
        logic [3:0] codes [4];
        exp_t e;
        int top;
        top = 0;
        for (int k = 0; k < 4; k++)
            if (d[4*k +: 4] != 4'h0 || dt[k]) top = k;
        for (int k = 0; k < 4; k++)
            codes[k] = (lz && k > top) ? 4'hF : d[4*k +: 4];
        for (int s = 0; s < 4; s++) begin
            for (int p = 0; p < 4; p++) begin
                e.code = codes[s];
                e.dot  = ~dt[s];
                e.an   = (p < blank) ? 4'b1111 : ~(4'b0001 << s);
                e.tick = (s == 0 && p == 0);
                q.push_back(e);
            end
        end
    endtask

    task automatic check_cycles(input int n, input bit sel0, input string name);
        exp_t e;
        logic [3:0] c, an;
        logic dd, t;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (q.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL %s cycle %0d: scoreboard empty, got output without expectation", name, i);
            end else begin
                e  = q.pop_front();
                c  = sel0 ? bus0.digit_code : bus.digit_code;
                dd = sel0 ? bus0.digit_dot  : bus.digit_dot;
                an = sel0 ? bus0.anode_n    : bus.anode_n;
                t  = sel0 ? bus0.frame_tick : bus.frame_tick;
                vectors += 4;
                if (c !== e.code) begin
                    miscompares++;
                    $display("FAIL %s cycle %0d digit_code: got %h expected %h", name, i, c, e.code);
                end
                if (dd !== e.dot) begin
                    miscompares++;
                    $display("FAIL %s cycle %0d digit_dot: got %b expected %b", name, i, dd, e.dot);
                end
                if (an !== e.an) begin
                    miscompares++;
                    $display("FAIL %s cycle %0d anode_n: got %b expected %b", name, i, an, e.an);
                end
                if (t !== e.tick) begin
                    miscompares++;
                    $display("FAIL %s cycle %0d frame_tick: got %b expected %b", name, i, t, e.tick);
                end
            end
        end
    endtask

    task automatic check_reset_values(input string name);
        vectors += 4;
        if (bus.digit_code !== 4'hF) begin
            miscompares++;
            $display("FAIL %s digit_code: got %h expected f", name, bus.digit_code);
        end
        if (bus.digit_dot !== 1'b1) begin
            miscompares++;
            $display("FAIL %s digit_dot: got %b expected 1", name, bus.digit_dot);
        end
        if (bus.anode_n !== 4'b1111) begin
            miscompares++;
            $display("FAIL %s anode_n: got %b expected 1111", name, bus.anode_n);
        end
        if (bus.frame_tick !== 1'b0) begin
            miscompares++;
            $display("FAIL %s frame_tick: got %b expected 0", name, bus.frame_tick);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        bus.digits_in   = 16'h4321;
        bus.dots_in     = 4'b0000;
        bus.lz_blank_en = 1'b0;
        bus0.digits_in   = 16'h8765;
        bus0.dots_in     = 4'b0000;
        bus0.lz_blank_en = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_values("reset_held");
        reset = 1'b0;
        push_frame(16'h4321, 4'b0000, 1'b0, 1);
        check_cycles(16, 1'b0, "post_reset");
    endtask

    task automatic test_snapshot();
        push_frame(16'h4321, 4'b0000, 1'b0, 1);
        check_cycles(6, 1'b0, "snap_pre");
        bus.digits_in = 16'h9999;
        check_cycles(10, 1'b0, "snap_hold");
        push_frame(16'h9999, 4'b0000, 1'b0, 1);
        check_cycles(16, 1'b0, "snap_new");
    endtask

    task automatic test_lz_blanking();
        logic [15:0] d_tab  [5] = '{16'h0050, 16'h0000, 16'h0000, 16'hA000, 16'h0050};
        logic [3:0]  dt_tab [5] = '{4'b0000, 4'b0000, 4'b0100, 4'b0000, 4'b0000};
        bit          lz_tab [5] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        for (int i = 0; i < 5; i++) begin
            bus.digits_in   = d_tab[i];
            bus.dots_in     = dt_tab[i];
            bus.lz_blank_en = lz_tab[i];
            push_frame(d_tab[i], dt_tab[i], lz_tab[i], 1);
            check_cycles(16, 1'b0, $sformatf("lz_case%0d", i));
        end
    endtask

    task automatic test_no_blank_window();
        push_frame(16'h8765, 4'b0000, 1'b0, 0);
        check_cycles(16, 1'b1, "blank0");
    endtask

    task automatic test_reset_mid_slot();
        push_frame(16'h0050, 4'b0000, 1'b0, 1);
        check_cycles(9, 1'b0, "pre_abort");
        #2;
        reset = 1'b1;
        #1;
        check_reset_values("async_reset");
        q.delete();
        @(negedge clk);
        bus.digits_in   = 16'h4321;
        bus.dots_in     = 4'b1000;
        bus.lz_blank_en = 1'b0;
        reset = 1'b0;
        push_frame(16'h4321, 4'b1000, 1'b0, 1);
        check_cycles(16, 1'b0, "restart");
    endtask

    initial begin
        test_reset();
        test_snapshot();
        test_lz_blanking();
        test_no_blank_window();
        test_reset_mid_slot();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/display_scanner.md
Name: display_scanner

Overview:
- Time-multiplexes N packed BCD digits onto one shared seven-segment decoder and a common-anode digit array.
- Sits directly upstream of the per-digit seven-segment decoder. Each slot it presents one digit code plus its dot, and drives the matching anode low.
- Snapshots the inputs once per frame, so a stopwatch or timer value cannot tear mid-scan.
- Optional leading-zero blanking and an anti-ghosting blank window at the start of each slot.

Parameters:
- NUM_DIGITS, 8: number of multiplexed digits; legal range 2..8.
- REFRESH_DIV, 50000: clock cycles per digit slot; must be ≥ 2.
- BLANK_CYCLES, 500: cycles at the start of each slot with all anodes off; must be < REFRESH_DIV; 0 disables the window.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- digits_in  in  4*NUM_DIGITS  packed BCD; digit k at [4k+3:4k]; digit 0 is rightmost
- dots_in  in  NUM_DIGITS  1 = decimal point of digit k lit
- lz_blank_en  in  1  1 = blank leading zeros
- digit_code  out  4  code to decoder; 4'hF = blank
- digit_dot  out  1  dot to decoder, active-low (0 = lit), matching segment polarity
- anode_n  out  NUM_DIGITS  active-low digit enables
- frame_tick  out  1  one-cycle pulse when a new frame starts and a new snapshot becomes visible

Interface (already decided):
- One clock (clk).
- Reset is asynchronous and active-high (reset).

Behaviour:
- State:
  - prescaler pre: 0..REFRESH_DIV-1.
  - slot index idx: 0..NUM_DIGITS-1.
  - shadow registers sh_code[NUM_DIGITS], sh_dot[NUM_DIGITS].
  - load_pending flag.
- Reset values (asynchronous, immediate):
  - pre = 0, idx = 0.
  - sh_code all 4'hF, sh_dot all 0.
  - load_pending = 1.
  - digit_code = 4'hF, digit_dot = 1, anode_n all ones, frame_tick = 0.
- Prescaler:
  - pre increments every cycle.
  - At pre == REFRESH_DIV-1: pre wraps to 0 and idx advances (idx == NUM_DIGITS-1 wraps to 0). This edge is the slot boundary.
- Snapshot. sh_code/sh_dot load from digits_in/dots_in, with leading-zero blanking applied, when either:
  - it is the slot boundary with idx == NUM_DIGITS-1 (frame wrap), or
  - it is the first clock after reset deassertion (load_pending == 1; the flag then clears).
  - The post-reset load does not advance idx or pre.
  - Inputs are sampled only at those edges; changes elsewhere have no visible effect until the next frame.
- frame_tick:
  - 1 for exactly the cycle following each snapshot edge; otherwise 0.
  - Fires on the post-reset load and on every frame wrap.
- Leading-zero blanking (applied at snapshot, combinationally from the inputs):
  - If lz_blank_en = 1, scan from digit NUM_DIGITS-1 downward.
  - Each digit whose code is 0 and whose dot is 0 is stored as 4'hF, until the first nonzero code or lit dot is reached.
  - Digit 0 is never blanked.
  - If lz_blank_en = 0, codes are stored verbatim.
  - Codes 10..15 are passed through unchanged (the decoder blanks them) and count as nonzero.
- Outputs (registered; updated on the same edge idx/pre update, computed from next-state values so there is zero skew):
  - digit_code = sh_code[idx].
  - digit_dot = ~sh_dot[idx].
  - anode_n = all ones while pre < BLANK_CYCLES.
  - Otherwise anode_n has only bit idx low.
  - On the post-reset load edge, outputs use the newly loaded values.
- Simultaneous events: a frame-wrap snapshot and the idx wrap happen on the same edge. Slot 0 of the new frame shows the new snapshot.
- Reset mid-slot or mid-frame aborts immediately to reset values; the scan restarts at idx 0 after release.

Decomposition:
- display_pkg:
  - BLANK_CODE = 4'hF.
  - digit_code_t (logic [3:0]).
  - MAX_DIGITS = 8.
- Sub-module lz_blanker (combinational): takes the packed codes, dots and lz_blank_en; returns the blanked code array. It is instantiated once at the snapshot input.

Test Plan (NUM_DIGITS=4, REFRESH_DIV=4, BLANK_CYCLES=1 unless noted):
- Reset checks:
  - While reset is held: digit_code=F, digit_dot=1, anode_n=1111, frame_tick=0.
  - Release with digits_in=16'h4321, dots=0000, lz off: frame_tick pulses once.
  - digit_code then sequences 1,2,3,4, each for 4 cycles.
  - anode_n is 1111 for 1 cycle, then 1110 / 1101 / 1011 / 0111 for 3 cycles each.
- Snapshot isolation: change digits_in to 16'h9999 during slot 1 → slots 2–3 still show 3,4; slot 0 of the next frame shows 9 in the same cycle frame_tick=1.
- Leading-zero blanking: digits_in=16'h0050, lz on → codes F,F,5,0 (digits 3..0). digits_in=16'h0000 → F,F,F,0. dots=0100 with 16'h0000 → F,0,0,0; digit 2 dot → digit_dot=0 during slot 2.
- Out-of-range codes: digits_in=16'hA000, lz on → digit 3 keeps A, digits 2..0 show 0.
- Blank window: BLANK_CYCLES=0 → anode_n never 1111 after the first slot. Reset asserted mid-slot 2 → outputs revert to reset values asynchronously, without waiting for a clock edge.
